// File: rtl/bin2rns_seq_pkg.sv
//----------------------------------------------------------------------------
// bin2rns_seq_pkg - shared sizes and FSM encoding for the forward RNS converter
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package bin2rns_seq_pkg;
    localparam int MOD_NUM  = 4;
    localparam int MOD_SIZE = 3;
    localparam int RANGE    = MOD_NUM * MOD_SIZE;
    localparam int CNT_W    = $clog2(RANGE + 1);
    localparam int PROD_W   = MOD_NUM * (MOD_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

`default_nettype wire

// File: rtl/bin2rns_lane.sv
//----------------------------------------------------------------------------
// bin2rns_lane - one modulus lane: bit-serial reduction, sign fix, illegal-modulus forcing
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module bin2rns_lane
    import bin2rns_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                fix,
    input  logic                bit_in,
    input  logic                neg,
    input  logic [MOD_SIZE:0]   mod_in,
    output logic [MOD_SIZE-1:0] res,
    output logic                bad
);
    localparam logic [MOD_SIZE:0] M_MAX = (MOD_SIZE + 1)'(1 << MOD_SIZE);

    logic [MOD_SIZE:0]   m;
    logic [MOD_SIZE+1:0] t;
    logic [MOD_SIZE+1:0] t_red;
    logic [MOD_SIZE:0]   neg_r;

    assign bad   = (m == '0) || (m > M_MAX);
    // r < m <= 2^MOD_SIZE keeps 2r+b below 2m, so a single subtract is enough
    assign t     = {1'b0, res, bit_in};
    assign t_red = (t >= {1'b0, m}) ? (t - {1'b0, m}) : t;
    assign neg_r = m - {1'b0, res};

    always_ff @(posedge clk) begin
        if (reset) begin
            m   <= '0;
            res <= '0;
        end else if (load) begin
            m   <= mod_in;
            res <= '0;
        end else if (step) begin
            res <= MOD_SIZE'(t_red);
        end else if (fix) begin
            if (bad)
                res <= '0;
            else if (neg && (res != '0))
                res <= MOD_SIZE'(neg_r);
        end
    end
endmodule

`default_nettype wire

// File: rtl/bin2rns_seq.sv
//----------------------------------------------------------------------------
// bin2rns_seq - sequential signed binary to 4-modulus RNS converter with handshakes
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module bin2rns_seq
    import bin2rns_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RANGE-1:0]    x_in,
    input  logic [MOD_SIZE:0]   mod_1,
    input  logic [MOD_SIZE:0]   mod_2,
    input  logic [MOD_SIZE:0]   mod_3,
    input  logic [MOD_SIZE:0]   mod_4,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MOD_SIZE-1:0] c0,
    output logic [MOD_SIZE-1:0] c1,
    output logic [MOD_SIZE-1:0] c2,
    output logic [MOD_SIZE-1:0] c3,
    output logic                err
);
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [RANGE-1:0]     mag;
    logic                 sign;
    logic [PROD_W-1:0]    mprod;

    logic                 accept;
    logic [RANGE-1:0]     x_abs;
    logic [PROD_W-1:0]    half;
    logic [PROD_W-1:0]    mag_ext;
    logic                 out_of_range;
    logic [MOD_SIZE:0]    mods [MOD_NUM];
    logic [MOD_SIZE-1:0]  res  [MOD_NUM];
    logic [MOD_NUM-1:0]   bad;

    assign accept  = in_valid && in_ready;
    assign x_abs   = x_in[RANGE-1] ? (~x_in + RANGE'(1)) : x_in;
    assign half    = mprod >> 1;
    assign mag_ext = PROD_W'(mag);
    // Negative side of the legal range includes -floor(M/2) itself
    assign out_of_range = sign ? (mag_ext > half) : (mag_ext >= half);

    assign mods[0] = mod_1;
    assign mods[1] = mod_2;
    assign mods[2] = mod_3;
    assign mods[3] = mod_4;
    assign c0 = res[0];
    assign c1 = res[1];
    assign c2 = res[2];
    assign c3 = res[3];

    generate
        for (genvar i = 0; i < MOD_NUM; i++) begin : g_lane
            bin2rns_lane u_lane (
                .clk    (clk),
                .reset  (reset),
                .load   (accept),
                .step   (state == RUN),
                .fix    (state == FIX),
                .bit_in (mag[RANGE-1]),
                .neg    (sign),
                .mod_in (mods[i]),
                .res    (res[i]),
                .bad    (bad[i])
            );
        end
    endgenerate

    // The magnitude rotates rather than shifts so it is intact again for the range check in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mag       <= '0;
            sign      <= 1'b0;
            mprod     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag      <= x_abs;
                        sign     <= x_in[RANGE-1];
                        mprod    <= PROD_W'(mod_1) * PROD_W'(mod_2) * PROD_W'(mod_3) * PROD_W'(mod_4);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    mag <= {mag[RANGE-2:0], mag[RANGE-1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(RANGE - 1))
                        state <= FIX;
                end
                FIX: begin
                    err       <= out_of_range || (|bad);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
